// File: rtl/id_ex_stage.sv
// ID/EX stage: register-file addressing, MEM/WB operand bypass, stall detection and the ID/EX register.
// Define ID_EX_PERF_EN to add the o_stall_cycles counter output.
module id_ex_stage #(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic              i_use_rs,
  input  logic              i_use_rt,
  input  logic [4:0]        i_dest,
  input  logic [31:0]       i_imm,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [4:0]        o_read_register1,
  output logic [4:0]        o_read_register2,
  input  logic [31:0]       i_read_data1,
  input  logic [31:0]       i_read_data2,
  input  logic              i_mem_reg_write,
  input  logic [4:0]        i_mem_rd,
  input  logic              i_mem_is_load,
  input  logic [31:0]       i_mem_result,
  input  logic              i_wb_reg_write,
  input  logic [4:0]        i_wb_write_register,
  input  logic [31:0]       i_wb_write_data,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_valid,
  output logic [31:0]       o_rs_data,
  output logic [31:0]       o_rt_data,
  output logic [4:0]        o_dest,
  output logic [31:0]       o_imm,
  output logic [CTRL_W-1:0] o_ctrl
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);

  logic [1:0][4:0]  src;
  logic [1:0][31:0] rf_data;
  logic [1:0]       use_flag;
  logic [1:0][31:0] fwd_data;
  logic [1:0]       hazard;
  logic             load_bubble;

  logic              valid_reg;
  logic [31:0]       rs_data_reg;
  logic [31:0]       rt_data_reg;
  logic [4:0]        dest_reg;
  logic [31:0]       imm_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  assign src[0]      = i_rs;
  assign src[1]      = i_rt;
  assign rf_data[0]  = i_read_data1;
  assign rf_data[1]  = i_read_data2;
  assign use_flag[0] = i_use_rs;
  assign use_flag[1] = i_use_rt;

  assign o_read_register1 = i_rs;
  assign o_read_register2 = i_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // MEM beats WB; a load in MEM has no data yet, so it never forwards.
      assign fwd_data[gi] =
        (src[gi] == 5'd0) ? 32'd0 :
        (i_mem_reg_write && !i_mem_is_load && (i_mem_rd == src[gi])) ? i_mem_result :
        (i_wb_reg_write && (i_wb_write_register == src[gi])) ? i_wb_write_data :
        rf_data[gi];

      assign hazard[gi] = i_valid && use_flag[gi] && (src[gi] != 5'd0) &&
        ((valid_reg && ctrl_reg[0] && (dest_reg == src[gi])) ||
         (i_mem_reg_write && i_mem_is_load && (i_mem_rd == src[gi])));
    end
  endgenerate

  assign o_stall     = (|hazard) && !i_flush && !reset;
  assign load_bubble = i_flush || o_stall || !i_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      dest_reg    <= '0;
      imm_reg     <= '0;
      ctrl_reg    <= '0;
    end else if (load_bubble) begin
      valid_reg   <= 1'b0;
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      dest_reg    <= '0;
      imm_reg     <= '0;
      ctrl_reg    <= '0;
    end else begin
      valid_reg   <= 1'b1;
      rs_data_reg <= fwd_data[0];
      rt_data_reg <= fwd_data[1];
      dest_reg    <= i_dest;
      imm_reg     <= i_imm;
      ctrl_reg    <= i_ctrl;
    end
  end

  assign o_valid   = valid_reg;
  assign o_rs_data = rs_data_reg;
  assign o_rt_data = rt_data_reg;
  assign o_dest    = dest_reg;
  assign o_imm     = imm_reg;
  assign o_ctrl    = ctrl_reg;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] stall_cycles_next;

  // Free-running count of stalled edges; wraps naturally.
  assign stall_cycles_next = stall_cycles_reg + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= '0;
    end else if (o_stall) begin
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  assign o_stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor pops and compares each cycle.
module tb_id_ex_stage;
  localparam int CTRL_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              i_valid, i_use_rs, i_use_rt, i_flush;
  logic [4:0]        i_rs, i_rt, i_dest, i_mem_rd, i_wb_write_register;
  logic [31:0]       i_imm, i_read_data1, i_read_data2, i_mem_result, i_wb_write_data;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_mem_reg_write, i_mem_is_load, i_wb_reg_write;
  logic [4:0]        o_read_register1, o_read_register2, o_dest;
  logic              o_stall, o_valid;
  logic [31:0]       o_rs_data, o_rt_data, o_imm;
  logic [CTRL_W-1:0] o_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0]       o_stall_cycles;
`endif

  id_ex_stage #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_rs(i_rs), .i_rt(i_rt),
    .i_use_rs(i_use_rs), .i_use_rt(i_use_rt), .i_dest(i_dest), .i_imm(i_imm), .i_ctrl(i_ctrl),
    .o_read_register1(o_read_register1), .o_read_register2(o_read_register2),
    .i_read_data1(i_read_data1), .i_read_data2(i_read_data2),
    .i_mem_reg_write(i_mem_reg_write), .i_mem_rd(i_mem_rd), .i_mem_is_load(i_mem_is_load),
    .i_mem_result(i_mem_result), .i_wb_reg_write(i_wb_reg_write),
    .i_wb_write_register(i_wb_write_register), .i_wb_write_data(i_wb_write_data),
    .i_flush(i_flush), .o_stall(o_stall), .o_valid(o_valid), .o_rs_data(o_rs_data),
    .o_rt_data(o_rt_data), .o_dest(o_dest), .o_imm(o_imm), .o_ctrl(o_ctrl)
`ifdef ID_EX_PERF_EN
    , .o_stall_cycles(o_stall_cycles)
`endif
  );

  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] a, b, imm;
    logic [4:0]  dest;
    logic [7:0]  ctrl;
    logic [31:0] cnt;
    logic [4:0]  rs, rt;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Model of the instruction currently sitting in EX, plus the stall tally.
  bit        m_valid;
  bit        m_wr;
  bit [4:0]  m_dest;
  bit [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Architectural value of register s as the consumer should see it this cycle.
  function automatic logic [31:0] operand(input logic [4:0] s, input logic [31:0] rf);
    if (s == 0) return 32'd0;
    if (i_mem_reg_write && !i_mem_is_load && i_mem_rd == s) return i_mem_result;
    if (i_wb_reg_write && i_wb_write_register == s) return i_wb_write_data;
    return rf;
  endfunction

  // Register s is still being produced: ALU op in EX, or load in MEM.
  function automatic bit waits_on(input logic [4:0] s);
    return (m_valid && m_wr && m_dest == s) ||
           (i_mem_reg_write && i_mem_is_load && i_mem_rd == s);
  endfunction

  task automatic push_expected();
    exp_t e;
    bit st, take;
    st = !i_flush &&
         ((i_valid && i_use_rs && i_rs != 0 && waits_on(i_rs)) ||
          (i_valid && i_use_rt && i_rt != 0 && waits_on(i_rt)));
    take = i_valid && !i_flush && !st;
    e.stall = st;
    e.valid = take;
    e.a     = take ? operand(i_rs, i_read_data1) : 32'd0;
    e.b     = take ? operand(i_rt, i_read_data2) : 32'd0;
    e.imm   = take ? i_imm : 32'd0;
    e.dest  = take ? i_dest : 5'd0;
    e.ctrl  = take ? i_ctrl : 8'd0;
    e.rs    = i_rs;
    e.rt    = i_rt;
    if (st) m_cnt = m_cnt + 1;
    e.cnt   = m_cnt;
    m_valid = take;
    m_wr    = take && i_ctrl[0];
    m_dest  = i_dest;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    i_valid = 0; i_use_rs = 0; i_use_rt = 0; i_flush = 0;
    i_rs = 0; i_rt = 0; i_dest = 0; i_imm = 0; i_ctrl = 0;
    i_read_data1 = 0; i_read_data2 = 0;
    i_mem_reg_write = 0; i_mem_rd = 0; i_mem_is_load = 0; i_mem_result = 0;
    i_wb_reg_write = 0; i_wb_write_register = 0; i_wb_write_data = 0;
  endtask

  task automatic random_txn();
    step();
    i_valid = ($urandom_range(0, 9) != 0);
    i_rs = 5'($urandom_range(0, 7)); i_rt = 5'($urandom_range(0, 7));
    i_use_rs = 1'($urandom_range(0, 1)); i_use_rt = 1'($urandom_range(0, 1));
    i_dest = 5'($urandom_range(0, 7)); i_imm = $urandom; i_ctrl = 8'($urandom);
    i_read_data1 = $urandom; i_read_data2 = $urandom;
    i_mem_reg_write = 1'($urandom_range(0, 1)); i_mem_rd = 5'($urandom_range(0, 7));
    i_mem_is_load = ($urandom_range(0, 2) == 0); i_mem_result = $urandom;
    i_wb_reg_write = 1'($urandom_range(0, 1)); i_wb_write_register = 5'($urandom_range(0, 7));
    i_wb_write_data = $urandom;
    i_flush = ($urandom_range(0, 15) == 0);
    push_expected();
  endtask

  // Monitor: o_stall sampled mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      s = o_stall;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_txn++;
        chk("stall", {31'd0, s}, {31'd0, e.stall});
        chk("valid", {31'd0, o_valid}, {31'd0, e.valid});
        chk("rs_data", o_rs_data, e.a);
        chk("rt_data", o_rt_data, e.b);
        chk("dest", {27'd0, o_dest}, {27'd0, e.dest});
        chk("imm", o_imm, e.imm);
        chk("ctrl", {24'd0, o_ctrl}, {24'd0, e.ctrl});
`ifdef ID_EX_PERF_EN
        chk("stall_cycles", o_stall_cycles, e.cnt);
`endif
        $display("txn %0d rs=%0d rt=%0d stall=%0b valid=%0b a=%h b=%h", n_txn, e.rs, e.rt, s, o_valid, o_rs_data, o_rt_data);
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    m_valid = 0; m_wr = 0; m_dest = 0; m_cnt = 0;
    // Load hazard presented during reset must not raise o_stall.
    i_valid = 1; i_use_rt = 1; i_rt = 7; i_mem_reg_write = 1; i_mem_is_load = 1; i_mem_rd = 7;
    #12;
    chk("reset_stall", {31'd0, o_stall}, 32'd0);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ctrl", {24'd0, o_ctrl}, 32'd0);
    chk("reset_rs_data", o_rs_data, 32'd0);
    chk("reset_read_addr2", {27'd0, o_read_register2}, 32'd7);
    idle();
    @(negedge clk);
    reset = 0;

    // No hazard.
    step(); idle();
    i_valid = 1; i_use_rs = 1; i_rs = 3; i_read_data1 = 32'h11; i_dest = 3; i_imm = 32'h5;
    push_expected();
    // ALU dependence: producer, stalled consumer, then forwarded from MEM.
    step(); idle();
    i_valid = 1; i_dest = 5; i_ctrl = 8'h01; i_imm = 32'h77;
    push_expected();
    step(); idle();
    i_valid = 1; i_use_rs = 1; i_rs = 5; i_read_data1 = 32'h9999; i_dest = 6;
    push_expected();
    step(); idle();
    i_valid = 1; i_use_rs = 1; i_rs = 5; i_read_data1 = 32'h9999; i_dest = 6;
    i_mem_reg_write = 1; i_mem_rd = 5; i_mem_result = 32'h1234;
    push_expected();
    // Load-use: EX-stage stall, MEM-stage load stall, then WB forward.
    step(); idle();
    i_valid = 1; i_dest = 7; i_ctrl = 8'h03;
    push_expected();
    step(); idle();
    i_valid = 1; i_use_rt = 1; i_rt = 7; i_read_data2 = 32'hAAAA; i_dest = 8;
    push_expected();
    step(); idle();
    i_valid = 1; i_use_rt = 1; i_rt = 7; i_read_data2 = 32'hAAAA; i_dest = 8;
    i_mem_reg_write = 1; i_mem_is_load = 1; i_mem_rd = 7; i_mem_result = 32'hDEAD;
    push_expected();
    step(); idle();
    i_valid = 1; i_use_rt = 1; i_rt = 7; i_read_data2 = 32'hAAAA; i_dest = 8;
    i_wb_reg_write = 1; i_wb_write_register = 7; i_wb_write_data = 32'hBEEF;
    push_expected();
    // MEM beats WB.
    step(); idle();
    i_valid = 1; i_use_rs = 1; i_rs = 9; i_read_data1 = 32'h3;
    i_mem_reg_write = 1; i_mem_rd = 9; i_mem_result = 32'h1;
    i_wb_reg_write = 1; i_wb_write_register = 9; i_wb_write_data = 32'h2;
    push_expected();
    // r0 never forwards and never stalls.
    step(); idle();
    i_valid = 1; i_use_rs = 1; i_use_rt = 1; i_read_data1 = 32'h55; i_read_data2 = 32'h66;
    i_mem_reg_write = 1; i_mem_is_load = 1; i_mem_rd = 0;
    push_expected();
    // Flush overrides a stall.
    step(); idle();
    i_valid = 1; i_dest = 4; i_ctrl = 8'h01;
    push_expected();
    step(); idle();
    i_valid = 1; i_use_rs = 1; i_rs = 4; i_ctrl = 8'hF1; i_flush = 1;
    push_expected();

    for (int i = 0; i < 300; i++) random_txn();

    // Reset asserted between edges while a load-use stall is in progress.
    step(); idle();
    i_valid = 1; i_use_rt = 1; i_rt = 7; i_mem_reg_write = 1; i_mem_is_load = 1; i_mem_rd = 7;
    #1;
    chk("pre_reset_stall", {31'd0, o_stall}, 32'd1);
    #1;
    reset = 1;
    #1;
    chk("midreset_stall", {31'd0, o_stall}, 32'd0);
    chk("midreset_valid", {31'd0, o_valid}, 32'd0);
    chk("midreset_ctrl", {24'd0, o_ctrl}, 32'd0);
`ifdef ID_EX_PERF_EN
    chk("midreset_stall_cycles", o_stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("held_reset_valid", {31'd0, o_valid}, 32'd0);
    idle();
    @(negedge clk);
    reset = 0;
    m_valid = 0; m_wr = 0; m_dest = 0; m_cnt = 0;

    for (int i = 0; i < 40; i++) random_txn();

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute stage of the 5-stage pipelined CPU; sits directly downstream of the register file.
- Drives the register file read addresses and takes its read data.
- Resolves operand bypassing from the MEM and WB stages, and detects data hazards that need a stall.
- Holds the ID/EX pipeline register that feeds the EX stage, including bubble insertion on stall or flush.

Parameters:
- CTRL_W, 8, width of the opaque control bundle; bit 0 = reg_write, bit 1 = mem_read, other bits pass through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_valid  in  1  IF/ID holds a real instruction
- i_rs  in  5  source register 1 index
- i_rt  in  5  source register 2 index
- i_use_rs  in  1  instruction reads rs
- i_use_rt  in  1  instruction reads rt
- i_dest  in  5  destination register index (already selected by decode)
- i_imm  in  32  extended immediate
- i_ctrl  in  CTRL_W  decoded control bundle
- o_read_register1  out  5  register file read address 1 (= i_rs)
- o_read_register2  out  5  register file read address 2 (= i_rt)
- i_read_data1  in  32  register file read data 1
- i_read_data2  in  32  register file read data 2
- i_mem_reg_write  in  1  EX/MEM instruction writes a register
- i_mem_rd  in  5  EX/MEM destination
- i_mem_is_load  in  1  EX/MEM instruction is a load (result not yet available)
- i_mem_result  in  32  EX/MEM ALU result
- i_wb_reg_write  in  1  WB write enable (same signal as the register file write port)
- i_wb_write_register  in  5  WB destination
- i_wb_write_data  in  32  WB data
- i_flush  in  1  EX branch redirect; kill the instruction in ID
- o_stall  out  1  hold PC and IF/ID this cycle
- o_valid  out  1  ID/EX valid
- o_rs_data  out  32  resolved operand 1
- o_rt_data  out  32  resolved operand 2
- o_dest  out  5  registered destination
- o_imm  out  32  registered immediate
- o_ctrl  out  CTRL_W  registered control bundle (all zero when invalid)

Behaviour:
Reset:
- All registered outputs are 0, including o_valid.
- o_stall is forced to 0 while reset is high.
- Reset asserted mid-stall drops the bubble and the stall immediately.

Operand resolution (combinational, per source s):
- If s == 0, the result is 0.
- Else if i_mem_reg_write && i_mem_rd == s && !i_mem_is_load, take i_mem_result.
- Else if i_wb_reg_write && i_wb_write_register == s, take i_wb_write_data. This covers the case where the register file is being written on the same edge.
- Else take the register file data.
- MEM has priority over WB.

Hazard detection; the "use" condition is i_valid && i_use_x && x != 0:
- EX hazard: o_valid && o_ctrl[0] && o_dest == x. The result is not yet computed, so stall.
- Load hazard: i_mem_reg_write && i_mem_is_load && i_mem_rd == x. Stall.
- The net effect is a 1-cycle stall for an ALU-to-use dependence and a 2-cycle stall for load-to-use.
- o_stall = (hazard on rs or rt) && !i_flush && !reset.

Register update on posedge clk:
- i_flush, or o_stall, or !i_valid: load a bubble. o_valid = 0 and o_ctrl = 0; o_dest, o_imm and data are don't-care but are driven to 0.
- Otherwise: capture the resolved operands, i_dest, i_imm, i_ctrl, and set o_valid = 1.
- Flush has priority over stall.
- Latency from ID to the EX-facing outputs is 1 cycle.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- Enabled:
  - Adds output o_stall_cycles (32 bit).
  - Increments on every clock edge where o_stall = 1.
  - Wraps 0xFFFFFFFF to 0.
  - Cleared by reset.
- Disabled: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- No hazard: i_rs=3, i_read_data1=0x11, all forward sources idle -> next cycle o_rs_data=0x11, o_valid=1; o_stall stays 0.
- ALU dependence:
  - Cycle 0: producer captured with o_dest=5, ctrl[0]=1.
  - Cycle 1: consumer has rs=5 -> o_stall=1 for 1 cycle and a bubble is loaded.
  - Cycle 2: i_mem_rd=5, i_mem_result=0x1234 -> o_rs_data=0x1234.
- Load-use: consumer rt=7 after a load to r7 -> o_stall high for 2 cycles; then i_wb_write_register=7, i_wb_write_data=0xBEEF while i_read_data2=0xAAAA -> o_rt_data=0xBEEF.
- Priority and r0:
  - MEM (0x1) and WB (0x2) both target r9 -> operand is 0x1.
  - rs=0 with i_mem_rd=0 -> operand 0 and no stall.
- Flush during stall: hazard present with i_flush=1 -> o_stall=0, next o_valid=0 and o_ctrl=0.
- Reset mid-operation: assert reset asynchronously between edges -> o_valid=0 and o_stall=0 immediately; with ID_EX_PERF_EN defined, o_stall_cycles=0 and the counter counts 3 after the load-use plus ALU sequence.
